// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 4800;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 48000;
  localparam int DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous bit, async reset to 0.
module sync_ff2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, filters lock, gates the system reset and retries on timeout.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] loss_count,
  output logic [2:0] state
);

  localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(MAX_RETRIES + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0] RTY_MAX  = NW'(MAX_RETRIES);

  state_t        cur, nxt;
  logic [RW-1:0] rst_cnt, rst_cnt_d;
  logic [SW-1:0] stb_cnt, stb_cnt_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [NW-1:0] retry, retry_d;
  logic          lock_s, loss_inc, timeout;

  sync_ff2 u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign timeout = (tmr == TMR_LAST);

  always_comb begin
    nxt       = cur;
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    tmr_d     = tmr;
    retry_d   = retry;
    loss_inc  = 1'b0;
    case (cur)
      ST_RESET_PLL: begin
        if (rst_cnt == RST_LAST) begin
          nxt   = ST_WAIT_LOCK;
          tmr_d = '0;
        end else begin
          rst_cnt_d = rst_cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        tmr_d = tmr + 1'b1;
        // timeout wins over a lock that completes on the same edge
        if (timeout) begin
          retry_d = retry + 1'b1;
          tmr_d   = '0;
          nxt     = (retry_d == RTY_MAX) ? ST_FAIL : ST_RESET_PLL;
        end else if (cur == ST_WAIT_LOCK) begin
          if (lock_s) begin
            nxt       = ST_STABLE;
            stb_cnt_d = SW'(1);
          end
        end else if (!lock_s) begin
          nxt = ST_WAIT_LOCK;
        end else if (stb_cnt == STB_LAST) begin
          nxt     = ST_RUN;
          retry_d = '0;
        end else begin
          stb_cnt_d = stb_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          nxt      = ST_RESET_PLL;
          loss_inc = 1'b1;
        end
      end
      default: ;
    endcase
    if (req_reset) begin
      nxt       = ST_RESET_PLL;
      rst_cnt_d = '0;
      stb_cnt_d = '0;
      tmr_d     = '0;
      retry_d   = '0;
      loss_inc  = 1'b0;
    end
  end

  // outputs are registered from the next state so they align with `state`
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cur        <= ST_RESET_PLL;
      rst_cnt    <= '0;
      stb_cnt    <= '0;
      tmr        <= '0;
      retry      <= '0;
      loss_count <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      cur     <= nxt;
      rst_cnt <= rst_cnt_d;
      stb_cnt <= stb_cnt_d;
      tmr     <= tmr_d;
      retry   <= retry_d;
      if (loss_inc && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
      pll_rst <= (nxt == ST_RESET_PLL) || (nxt == ST_FAIL);
      sys_rst <= (nxt != ST_RUN);
      ready   <= (nxt == ST_RUN);
      fail    <= (nxt == ST_FAIL);
    end
  end

  assign state = cur;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the main system PLL (48 MHz reference in; 150/75/50 MHz out) from power-up through stable lock. Asserts the PLL reset, waits for a filtered lock, and only then releases the system reset. On loss of lock it re-asserts the system reset and re-runs the sequence. After repeated lock timeouts it parks in a failure state. It runs on the 48 MHz reference clock, sits between the board reset and the PLL wrapper, and drives the reset inputs of all PLL-clocked logic.

## Interface
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 4800: consecutive synchronized lock-high samples required before release (100 µs at 48 MHz).
- LOCK_TIMEOUT_CYCLES, 48000: cycle budget per attempt, measured from end of `pll_rst` pulse to reaching RUN.
- MAX_RETRIES, 3: consecutive timed-out attempts before entering FAIL (≥1).
- clkin  in  1  48 MHz reference clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  raw PLL lock output, asynchronous to `clkin`.
- req_reset  in  1  single-cycle software/host request to re-sequence the PLL.
- pll_rst  out  1  drives PLL RST input (PLL instance built with reset enabled).
- sys_rst  out  1  active-high reset for PLL-clocked logic; consumers synchronize deassertion into their own domains.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- loss_count  out  8  saturating count of lock losses seen in RUN.
- state  out  3  current state encoding, for debug/status register.

## Operation
- Lock input passes through a 2-flop synchronizer → `lock_s`; only `lock_s` is used.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL.
- RESET_PLL: `pll_rst`=1, `sys_rst`=1. Counts RST_PULSE_CYCLES, then goes to WAIT_LOCK. The attempt timer is cleared on exit.
- WAIT_LOCK: `pll_rst`=0. If `lock_s`=1, go to STABLE with the stable counter reset to 1.
- STABLE: the stable counter increments on each `lock_s`=1 sample. If `lock_s`=0, go back to WAIT_LOCK with the counter cleared. When the counter reaches LOCK_STABLE_CYCLES, go to RUN and clear the retry counter.
- The attempt timer runs through WAIT_LOCK and STABLE. When it reaches LOCK_TIMEOUT_CYCLES, the retry counter increments. If the retry counter now equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL. Timeout has priority over the STABLE→RUN transition in the same cycle.
- RUN: `sys_rst`=0, `ready`=1. If `lock_s`=0, `loss_count` increments (saturating at 255) and the block goes to RESET_PLL.
- FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Exited only by `req_reset` or `rst`.
- `req_reset`=1 in any state: go to RESET_PLL, clear the retry counter and attempt timer. It has priority over all other transitions. If it coincides with a lock drop in RUN, `loss_count` does not increment.
- `loss_count` is cleared only by `rst`.
- Counter widths are $clog2(max value + 1) of their respective parameter.

## Timing
- Reset values (async, while `rst`=1): state=RESET_PLL (3'd0), `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `loss_count`=0, all counters 0, synchronizer flops 0.
- All outputs are registered and change only on `clkin` rising edges.
- Encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- `pll_rst` pulse width is exactly RST_PULSE_CYCLES cycles per attempt.
- `sys_rst` falls on the edge that takes the LOCK_STABLE_CYCLES-th consecutive high `lock_s` sample. Latency from the first `lock_s` high cycle is LOCK_STABLE_CYCLES cycles; from the raw pin it is 2 more.
- Lock loss in RUN: `sys_rst`, `pll_rst` and `loss_count` update on the edge after the first `lock_s`=0 sample. Latency from the raw pin falling is 3 edges.
- A lock glitch shorter than one `clkin` period may be missed; this is accepted.
- A mid-sequence `rst` returns the block to reset values immediately, with no completion of the `pll_rst` pulse.

## Structure
- Package `pll_sup_pkg`: state enum with fixed encoding above, and default parameter constants.
- Sub-module `sync_ff2`: 2-flop synchronizer with async reset to 0, reusable for other CDC single bits.
- FSM, counters and output registers live in `pll_lock_supervisor`.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up: release `rst`, raise `pll_locked` 10 cycles later → `pll_rst` high exactly 4 cycles, `sys_rst` falls 2+8 edges after `pll_locked` rise, `ready`=1, state=3.
- Flapping lock: drop `pll_locked` for 2 cycles during STABLE → stable count restarts, `sys_rst` stays 1 until 8 fresh consecutive samples.
- Never locks: `pll_locked`=0 always → two 4-cycle `pll_rst` pulses 36 cycles apart, then state=4, `fail`=1, `pll_rst`=1; `req_reset` → restarts at RESET_PLL.
- Loss in RUN: drop `pll_locked` while in RUN → `sys_rst`=1 and `loss_count`=1 three edges after the drop, followed by a full re-sequence; repeat 256 times → `loss_count` holds at 255.
- Priority: `req_reset` in the same cycle as a lock drop in RUN → RESET_PLL, `loss_count` unchanged; async `rst` pulse mid-STABLE → all outputs at reset values without waiting for a clock.
